// File: rtl/a_codec_tx.sv
// a_codec_tx: audio codec serial transmitter producing XCK/BCK/LRCK/DATA in I2S, left- or right-justified framing.
// Build option A_CODEC_TX_FIFO_EN selects a FIFO_DEPTH-entry stereo FIFO instead of a single holding register.
module a_codec_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCK_HALF   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [DATA_WIDTH-1:0] iSL,
  input  logic [DATA_WIDTH-1:0] iSR,
  input  logic                  iVALID,
  output logic                  oREADY,
  input  logic [1:0]            iMODE,
  input  logic                  iMUTE,
  output logic                  oAUD_XCK,
  output logic                  oAUD_BCK,
  output logic                  oAUD_LRCK,
  output logic                  oAUD_DATA,
  output logic                  oFRAME,
  output logic                  oUNDERRUN
);

  localparam int PW = $clog2(2 * SLOT_WIDTH);
  localparam int CW = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(2 * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] P_SLOT = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] P_DMSB = PW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] P_SMSB = PW'(SLOT_WIDTH - 1);
  localparam logic [PW-1:0] P_RJ   = PW'(SLOT_WIDTH - DATA_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(BCK_HALF - 1);

  // Elaboration-time guards on the configuration space.
  if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_badDataWidth
    $error("a_codec_tx: DATA_WIDTH must be within 8..32");
  end
  if (SLOT_WIDTH < DATA_WIDTH) begin : g_badSlotWidth
    $error("a_codec_tx: SLOT_WIDTH must be >= DATA_WIDTH");
  end
  if (BCK_HALF < 1) begin : g_badBckHalf
    $error("a_codec_tx: BCK_HALF must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badFifoDepth
    $error("a_codec_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [CW-1:0]         r_div;
  logic                  r_bck;
  logic                  r_xck;
  logic [PW-1:0]         r_pos;
  logic [1:0]            r_mode;
  logic                  r_mute;
  logic [DATA_WIDTH-1:0] r_curL;
  logic [DATA_WIDTH-1:0] r_curR;
  logic                  r_lrck;
  logic                  r_data;
  logic                  r_frame;
  logic                  r_underrun;
  logic                  r_ready;

  logic                  w_tick;
  logic                  w_fall;
  logic                  w_frameStart;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_fullNext;
  logic [DATA_WIDTH-1:0] w_headL;
  logic [DATA_WIDTH-1:0] w_headR;

  assign w_tick       = (r_div == C_LAST);
  assign w_fall       = w_tick && r_bck;
  assign w_frameStart = w_fall && (r_pos == P_LAST);
  assign w_push       = iVALID && r_ready;
  assign w_pop        = w_frameStart && !w_empty;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_div <= '0;
      r_bck <= 1'b0;
      r_xck <= 1'b0;
    end else begin
      r_xck <= ~r_xck;
      if (w_tick) begin
        r_div <= '0;
        r_bck <= ~r_bck;
      end else begin
        r_div <= r_div + CW'(1);
      end
    end
  end

`ifdef A_CODEC_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] F_DEPTH = NW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_memL [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_memR [FIFO_DEPTH];
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [NW-1:0]         r_count;
  logic [NW-1:0]         w_countNext;

  assign w_empty    = (r_count == '0);
  assign w_headL    = r_memL[r_rdPtr];
  assign w_headR    = r_memR[r_rdPtr];
  assign w_fullNext = (w_countNext == F_DEPTH);

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop) begin
      w_countNext = r_count + NW'(1);
    end else if (!w_push && w_pop) begin
      w_countNext = r_count - NW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_memL[r_wrPtr] <= iSL;
      r_memR[r_wrPtr] <= iSR;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= w_countNext;
    end
  end
`else
  logic [DATA_WIDTH-1:0] r_holdL;
  logic [DATA_WIDTH-1:0] r_holdR;
  logic                  r_holdValid;

  assign w_empty    = !r_holdValid;
  assign w_headL    = r_holdL;
  assign w_headR    = r_holdR;
  assign w_fullNext = w_push || (r_holdValid && !w_pop);

  // A push is only possible while empty, so it never collides with a pop.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_holdL     <= '0;
      r_holdR     <= '0;
      r_holdValid <= 1'b0;
    end else if (w_push) begin
      r_holdL     <= iSL;
      r_holdR     <= iSR;
      r_holdValid <= 1'b1;
    end else if (w_pop) begin
      r_holdValid <= 1'b0;
    end
  end
`endif

  logic [PW-1:0]         w_posNext;
  logic [PW-1:0]         w_lrPos;
  logic [PW-1:0]         w_k;
  logic [PW-1:0]         w_shift;
  logic [1:0]            w_modeEff;
  logic                  w_muteEff;
  logic [DATA_WIDTH-1:0] w_curL;
  logic [DATA_WIDTH-1:0] w_curR;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_right;
  logic                  w_inWord;
  logic                  w_lrck;
  logic                  w_bit;

  // Values for the position about to be entered; at a frame start the new
  // pair, mode and mute take effect immediately so the MSB lands on p=0.
  always_comb begin
    w_posNext = (r_pos == P_LAST) ? '0 : r_pos + PW'(1);
    w_modeEff = w_frameStart ? iMODE : r_mode;
    w_muteEff = w_frameStart ? iMUTE : r_mute;
    w_curL    = r_curL;
    w_curR    = r_curR;
    if (w_frameStart) begin
      w_curL = w_empty ? '0 : w_headL;
      w_curR = w_empty ? '0 : w_headR;
    end

    w_right  = (w_posNext >= P_SLOT);
    w_k      = w_right ? (w_posNext - P_SLOT) : w_posNext;
    w_word   = w_right ? w_curR : w_curL;
    w_inWord = 1'b0;
    w_shift  = '0;
    if (w_modeEff == 2'd2) begin
      if (w_k >= P_RJ) begin
        w_inWord = 1'b1;
        w_shift  = P_SMSB - w_k;
      end
    end else if (w_k <= P_DMSB) begin
      w_inWord = 1'b1;
      w_shift  = P_DMSB - w_k;
    end
    w_shifted = w_word >> w_shift;
    w_bit     = w_inWord && !w_muteEff && w_shifted[0];

    w_lrPos = (w_posNext == P_LAST) ? '0 : w_posNext + PW'(1);
    if (w_modeEff == 2'd1 || w_modeEff == 2'd2) begin
      w_lrck = w_right;
    end else begin
      w_lrck = (w_lrPos >= P_SLOT);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_pos      <= P_LAST;
      r_mode     <= 2'd0;
      r_mute     <= 1'b0;
      r_curL     <= '0;
      r_curR     <= '0;
      r_lrck     <= 1'b0;
      r_data     <= 1'b0;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_frame    <= w_frameStart;
      r_underrun <= w_frameStart && w_empty;
      r_ready    <= !w_fullNext;
      if (w_fall) begin
        r_pos  <= w_posNext;
        r_lrck <= w_lrck;
        r_data <= w_bit;
      end
      if (w_frameStart) begin
        r_mode <= iMODE;
        r_mute <= iMUTE;
        r_curL <= w_curL;
        r_curR <= w_curR;
      end
    end
  end

  assign oAUD_XCK  = r_xck;
  assign oAUD_BCK  = r_bck;
  assign oAUD_LRCK = r_lrck;
  assign oAUD_DATA = r_data;
  assign oFRAME    = r_frame;
  assign oUNDERRUN = r_underrun;
  assign oREADY    = r_ready;

endmodule
